// File: rtl/revaluate_engine_pkg.sv
// revaluate_engine_pkg
//   Shared constants and types for the revaluate (chi) engine.
//   LANES/ROWS describe the 5x5 state geometry, ROW_CNT_W sizes the row
//   counter, state_t is the engine FSM encoding.
package revaluate_engine_pkg;
    localparam int LANES     = 5;
    localparam int ROWS      = 5;
    localparam int ROW_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/revaluate_engine_if.sv
// revaluate_engine_if
//   Valid/ready bus of the revaluate engine, input and output channels.
//   Ports (signals):
//     in_valid/in_ready/in_data/mode   input state channel
//     out_valid/out_ready/out_data     result state channel
//   master: the producer/consumer side; slave: the engine side.
interface revaluate_engine_if #(parameter int W = 1);
    localparam int S = 25 * W;

    logic         in_valid;
    logic         in_ready;
    logic [S-1:0] in_data;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [S-1:0] out_data;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/revaluate_engine_row.sv
// revaluate_engine_row
//   Combinational chi over one row of five W-bit lanes, with bypass.
//   Ports:
//     a       in   5 lanes, lane 0 in the most significant slot
//     bypass  in   1 = copy a to b, 0 = chi
//     b       out  5 result lanes, same layout as a
module revaluate_engine_row
    import revaluate_engine_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [LANES-1:0][W-1:0] a,
    input  logic                    bypass,
    output logic [LANES-1:0][W-1:0] b
);
    // Lane x sits at packed index LANES-1-x so that lane 0 is the MSB end.
    for (genvar x = 0; x < LANES; x++) begin : g_lane
        localparam int X0 = LANES - 1 - x;
        localparam int X1 = LANES - 1 - ((x + 1) % LANES);
        localparam int X2 = LANES - 1 - ((x + 2) % LANES);
        assign b[X0] = bypass ? a[X0] : (a[X0] ^ (~a[X1] & a[X2]));
    end
endmodule

// File: rtl/revaluate_engine.sv
// revaluate_engine
//   Applies chi (or bypass copy) to a 5x5 state of W-bit lanes, one row
//   per cycle. Accepts a state, spends 5 RUN cycles, then presents the
//   result in DONE until the consumer takes it.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   asynchronous reset, active low
//     clr    in   synchronous clear, same effect as reset
//     bus    --   valid/ready input and output channels (slave side)
//     busy   out  high while rows are being processed
module revaluate_engine
    import revaluate_engine_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    revaluate_engine_if.slave      bus,
    output logic                   busy
);
    localparam int RW = LANES * W;

    state_t                      state, state_nxt;
    logic [ROW_CNT_W-1:0]        row;
    logic                        row_wrap;
    logic                        mode_q;
    logic [ROWS-1:0][RW-1:0]     in_q;
    logic [ROWS-1:0][RW-1:0]     out_q;
    logic [RW-1:0]               row_in;
    logic [RW-1:0]               row_out;
    logic [ROWS-1:0]             row_en;
    logic                        accept;

    assign row_wrap = (row == ROW_CNT_W'(ROWS - 1));
    assign accept   = bus.in_valid & bus.in_ready;

    // Row 0 is the MSB end, i.e. packed index ROWS-1.
    assign row_in = in_q[ROW_CNT_W'(ROWS - 1) - row];

    revaluate_engine_row #(.W(W)) u_row (
        .a      (row_in),
        .bypass (mode_q),
        .b      (row_out)
    );

    // One-hot write enable per output row; only the active row is written.
    for (genvar r = 0; r < ROWS; r++) begin : g_en
        assign row_en[r] = (state == RUN) && (row == ROW_CNT_W'(r));
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (row_wrap) state_nxt = DONE;
            end
            DONE: begin
                bus.in_ready = bus.out_ready;
                if (bus.out_ready) state_nxt = bus.in_valid ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            row    <= '0;
            mode_q <= 1'b0;
            in_q   <= '0;
            out_q  <= '0;
        end else if (clr) begin
            state  <= IDLE;
            row    <= '0;
            mode_q <= 1'b0;
            in_q   <= '0;
            out_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                in_q   <= bus.in_data;
                mode_q <= bus.mode;
                row    <= '0;
            end else if (state == RUN) begin
                row <= row_wrap ? '0 : row + 1'b1;
            end
            for (int r = 0; r < ROWS; r++) begin
                if (row_en[r]) out_q[ROWS-1-r] <= row_out;
            end
        end
    end

    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_q;
    assign busy          = (state == RUN);
endmodule

// File: tb/tb_revaluate_engine.sv
// tb_revaluate_engine
//   Directed W=1 scenarios plus a randomized W=64 run against a bit-level
//   reference model built directly from the chi definition and layout.
module tb_revaluate_engine;
    import revaluate_engine_pkg::*;

    logic clk = 1'b0;
    logic rst1, clr1, busy1;
    logic rst64, clr64, busy64;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    revaluate_engine_if #(.W(1))  i1 ();
    revaluate_engine_if #(.W(64)) i64 ();

    revaluate_engine #(.W(1)) u_dut1 (
        .clk(clk), .rst(rst1), .clr(clr1), .bus(i1), .busy(busy1)
    );
    revaluate_engine #(.W(64)) u_dut64 (
        .clk(clk), .rst(rst64), .clr(clr64), .bus(i64), .busy(busy64)
    );

    task automatic chk(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got ..%h expected ..%h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Reference: bit j of lane (x,y) is at 25w-1 - 5w*y - w*x - j.
    function automatic logic [1599:0] ref_f(input logic [1599:0] s, input logic byp, input int w);
        logic [1599:0] r;
        int p, p1, p2;
        r = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                for (int j = 0; j < w; j++) begin
                    p  = 25*w - 1 - 5*w*y - w*x - j;
                    p1 = 25*w - 1 - 5*w*y - w*((x+1)%5) - j;
                    p2 = 25*w - 1 - 5*w*y - w*((x+2)%5) - j;
                    r[p] = byp ? s[p] : (s[p] ^ (~s[p1] & s[p2]));
                end
        return r;
    endfunction

    task automatic d1_start(input logic [24:0] d, input logic m);
        i1.in_valid = 1'b1;
        i1.in_data  = d;
        i1.mode     = m;
        @(posedge clk); #1;
        i1.in_valid = 1'b0;
    endtask

    // Called one step after the accepting edge; ends one step after DONE entry.
    task automatic d1_finish(input logic [24:0] exp, input bit noise);
        for (int k = 0; k < 4; k++) begin
            chk("run_busy", busy1, 1'b1);
            chk("run_ovalid", i1.out_valid, 1'b0);
            chk("run_iready", i1.in_ready, 1'b0);
            if (noise) begin
                i1.in_valid = 1'b1;
                i1.in_data  = 25'($urandom());
                i1.mode     = ~i1.mode;
            end
            @(posedge clk); #1;
        end
        i1.in_valid = 1'b0;
        chk("run_busy4", busy1, 1'b1);
        chk("run_ovalid4", i1.out_valid, 1'b0);
        @(posedge clk); #1;
        chk("done_ovalid", i1.out_valid, 1'b1);
        chk("done_busy", busy1, 1'b0);
        chk("done_data", i1.out_data, exp);
    endtask

    task automatic d1_drain();
        i1.out_ready = 1'b1;
        @(posedge clk); #1;
        i1.out_ready = 1'b0;
        chk("drain_ovalid", i1.out_valid, 1'b0);
        chk("drain_iready", i1.in_ready, 1'b1);
    endtask

    initial begin
        logic [1599:0] q[$];
        int sent, got, cyc;

        rst1 = 1'b0; clr1 = 1'b0; rst64 = 1'b0; clr64 = 1'b0;
        i1.in_valid = 1'b0; i1.in_data = '0; i1.mode = 1'b0; i1.out_ready = 1'b0;
        i64.in_valid = 1'b0; i64.in_data = '0; i64.mode = 1'b0; i64.out_ready = 1'b0;
        #2;
        chk("rst_ovalid", i1.out_valid, 1'b0);
        chk("rst_odata", i1.out_data, '0);
        chk("rst_iready", i1.in_ready, 1'b1);
        chk("rst_busy", busy1, 1'b0);
        @(posedge clk); #1;
        rst1 = 1'b1; rst64 = 1'b1;
        @(posedge clk); #1;

        // Basic chi vectors, latency and busy window.
        d1_start(25'h1000000, 1'b0); d1_finish(25'h1200000, 1'b0); d1_drain();
        d1_start(25'h0000001, 1'b0); d1_finish(25'h0000005, 1'b0); d1_drain();
        d1_start(25'h1FFFFFF, 1'b0); d1_finish(25'h1FFFFFF, 1'b0); d1_drain();
        d1_start(25'h0000000, 1'b0); d1_finish(25'h0000000, 1'b0); d1_drain();

        // Bypass, with mode toggling and in_valid noise during RUN.
        d1_start(25'h0ABCDEF, 1'b1); d1_finish(25'h0ABCDEF, 1'b1); d1_drain();
        // Chi with noise during RUN.
        d1_start(25'h1234567, 1'b0);
        d1_finish(25'(ref_f(1600'(25'h1234567), 1'b0, 1)), 1'b1); d1_drain();

        // Stall in DONE, then back-to-back accept.
        d1_start(25'h1000000, 1'b0); d1_finish(25'h1200000, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("stall_data", i1.out_data, 25'h1200000);
            chk("stall_ovalid", i1.out_valid, 1'b1);
            chk("stall_iready", i1.in_ready, 1'b0);
        end
        i1.out_ready = 1'b1;
        i1.in_valid  = 1'b1;
        i1.in_data   = 25'h0000001;
        i1.mode      = 1'b0;
        #1;
        chk("b2b_iready", i1.in_ready, 1'b1);
        @(posedge clk); #1;
        i1.out_ready = 1'b0;
        i1.in_valid  = 1'b0;
        d1_finish(25'h0000005, 1'b0); d1_drain();

        // Async reset mid-RUN (row 2 pending).
        d1_start(25'h1000000, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        #1;
        chk("arst_ovalid", i1.out_valid, 1'b0);
        chk("arst_odata", i1.out_data, '0);
        chk("arst_iready", i1.in_ready, 1'b1);
        chk("arst_busy", busy1, 1'b0);
        @(posedge clk); #1;
        rst1 = 1'b1;
        d1_start(25'h0000001, 1'b0); d1_finish(25'h0000005, 1'b0);

        // clr in DONE wins over a simultaneous handshake.
        clr1 = 1'b1;
        i1.out_ready = 1'b1;
        i1.in_valid  = 1'b1;
        i1.in_data   = 25'h1FFFFFF;
        @(posedge clk); #1;
        clr1 = 1'b0; i1.out_ready = 1'b0; i1.in_valid = 1'b0;
        chk("clr_ovalid", i1.out_valid, 1'b0);
        chk("clr_odata", i1.out_data, '0);
        chk("clr_iready", i1.in_ready, 1'b1);
        chk("clr_busy", busy1, 1'b0);
        d1_start(25'h1000000, 1'b0); d1_finish(25'h1200000, 1'b0); d1_drain();

        // W=64 random run with producer gaps and consumer stalls.
        sent = 0; got = 0; cyc = 0;
        while (got < 1000 && cyc < 40000) begin
            @(posedge clk); #1;
            i64.in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 50; k++) i64.in_data[k*32 +: 32] = $urandom();
            i64.mode      = ($urandom_range(0, 7) == 0);
            i64.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (i64.out_valid && i64.out_ready) begin
                if (q.size() == 0) chk("v64_spurious", 1'b1, 1'b0);
                else chk("v64_data", i64.out_data, q.pop_front());
                got++;
            end
            if (i64.in_valid && i64.in_ready) begin
                q.push_back(ref_f(i64.in_data, i64.mode, 64));
                sent++;
            end
            cyc++;
        end
        chk("v64_count", 1600'(got), 1600'(1000));
        i64.in_valid = 1'b0;
        i64.out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
